bdf_switch: RTL

BDF_SWITCH -- requirements
Module: bdf_switch

---
 rtl/bdf_switch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bdf_switch.sv
// Dataflow switch node: a boolean control token steers the matching data token
// to one of two single-entry output registers; both inputs are FIFO-buffered.
module bdf_switch #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  input  logic             ctrl_in,
  input  logic             ctrl_in_valid,
  output logic             ctrl_in_ready,
  output logic [WIDTH-1:0] data_out_1,
  output logic             data_out_1_valid,
  input  logic             data_out_1_ready,
  output logic [WIDTH-1:0] data_out_2,
  output logic             data_out_2_valid,
  input  logic             data_out_2_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] d_mem_q [DEPTH];
  logic [DEPTH-1:0] c_mem_q;

  logic [AW-1:0]    d_wr_q, d_wr_d, d_rd_q, d_rd_d;
  logic [AW-1:0]    c_wr_q, c_wr_d, c_rd_q, c_rd_d;
  logic [AW:0]      d_cnt_q, d_cnt_d, c_cnt_q, c_cnt_d;
  logic             d_rdy_q, d_rdy_d, c_rdy_q, c_rdy_d;
  logic             o1_vld_q, o1_vld_d, o2_vld_q, o2_vld_d;
  logic [WIDTH-1:0] o1_dat_q, o1_dat_d, o2_dat_q, o2_dat_d;

  logic             d_push, c_push, d_empty, c_empty;
  logic             head_sel, free_1, free_2, fire, fire_1, fire_2;
  logic [WIDTH-1:0] head_data;

  // Handshakes and the fire decision for the head token pair.
  always_comb begin
    d_push    = data_in_valid & d_rdy_q;
    c_push    = ctrl_in_valid & c_rdy_q;
    d_empty   = (d_cnt_q == CNT_ZERO);
    c_empty   = (c_cnt_q == CNT_ZERO);
    head_sel  = c_mem_q[c_rd_q];
    head_data = d_mem_q[d_rd_q];
    free_1    = ~o1_vld_q | data_out_1_ready;
    free_2    = ~o2_vld_q | data_out_2_ready;
    fire      = ~d_empty & ~c_empty & (head_sel ? free_2 : free_1);
    fire_1    = fire & ~head_sel;
    fire_2    = fire & head_sel;
  end

  // Next-state for FIFO pointers, occupancies, readies and output slots.
  always_comb begin
    d_wr_d   = d_wr_q;
    d_rd_d   = d_rd_q;
    c_wr_d   = c_wr_q;
    c_rd_d   = c_rd_q;
    d_cnt_d  = d_cnt_q;
    c_cnt_d  = c_cnt_q;
    o1_vld_d = o1_vld_q;
    o1_dat_d = o1_dat_q;
    o2_vld_d = o2_vld_q;
    o2_dat_d = o2_dat_q;

    if (d_push) d_wr_d = d_wr_q + PTR_ONE;
    else        d_wr_d = d_wr_q;
    if (c_push) c_wr_d = c_wr_q + PTR_ONE;
    else        c_wr_d = c_wr_q;
    if (fire) begin
      d_rd_d = d_rd_q + PTR_ONE;
      c_rd_d = c_rd_q + PTR_ONE;
    end else begin
      d_rd_d = d_rd_q;
      c_rd_d = c_rd_q;
    end

    case ({d_push, fire})
      2'b10:   d_cnt_d = d_cnt_q + CNT_ONE;
      2'b01:   d_cnt_d = d_cnt_q - CNT_ONE;
      default: d_cnt_d = d_cnt_q;
    endcase
    case ({c_push, fire})
      2'b10:   c_cnt_d = c_cnt_q + CNT_ONE;
      2'b01:   c_cnt_d = c_cnt_q - CNT_ONE;
      default: c_cnt_d = c_cnt_q;
    endcase

    // Readies are registered from the next occupancy, so a pop on a full FIFO
    // only reopens the input after the edge.
    d_rdy_d = (d_cnt_d != CNT_FULL);
    c_rdy_d = (c_cnt_d != CNT_FULL);

    if (fire_1) begin
      o1_vld_d = 1'b1;
      o1_dat_d = head_data;
    end else if (data_out_1_ready) begin
      o1_vld_d = 1'b0;
    end else begin
      o1_vld_d = o1_vld_q;
    end

    if (fire_2) begin
      o2_vld_d = 1'b1;
      o2_dat_d = head_data;
    end else if (data_out_2_ready) begin
      o2_vld_d = 1'b0;
    end else begin
      o2_vld_d = o2_vld_q;
    end
  end

  // Control and state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_wr_q   <= '0;
      d_rd_q   <= '0;
      c_wr_q   <= '0;
      c_rd_q   <= '0;
      d_cnt_q  <= CNT_ZERO;
      c_cnt_q  <= CNT_ZERO;
      d_rdy_q  <= 1'b0;
      c_rdy_q  <= 1'b0;
      o1_vld_q <= 1'b0;
      o2_vld_q <= 1'b0;
      o1_dat_q <= '0;
      o2_dat_q <= '0;
    end else begin
      d_wr_q   <= d_wr_d;
      d_rd_q   <= d_rd_d;
      c_wr_q   <= c_wr_d;
      c_rd_q   <= c_rd_d;
      d_cnt_q  <= d_cnt_d;
      c_cnt_q  <= c_cnt_d;
      d_rdy_q  <= d_rdy_d;
      c_rdy_q  <= c_rdy_d;
      o1_vld_q <= o1_vld_d;
      o2_vld_q <= o2_vld_d;
      o1_dat_q <= o1_dat_d;
      o2_dat_q <= o2_dat_d;
    end
  end

  // FIFO storage; contents need no reset because empty pointers hide them.
  always_ff @(posedge clk) begin
    if (rst && d_push) d_mem_q[d_wr_q] <= data_in;
    if (rst && c_push) c_mem_q[c_wr_q] <= ctrl_in;
  end

  assign data_in_ready    = d_rdy_q;
  assign ctrl_in_ready    = c_rdy_q;
  assign data_out_1       = o1_dat_q;
  assign data_out_1_valid = o1_vld_q;
  assign data_out_2       = o2_dat_q;
  assign data_out_2_valid = o2_vld_q;

endmodule
